tempsens_meas_seq: RTL and testbench

Measurement sequencer for the ring-oscillator temperature sensor. It takes command bytes from the UART receiver and powers the ring oscillator for a settle period. It then gates the RO edge counter for a fixed window, latches the count and returns it as two bytes, high byte first, over the UART transmitter's valid/ready handshake. It sits between the UART RX/TX blocks and the RO counter.

---
 rtl/tempsens_pkg.sv | 19 +
 rtl/tempsens_window_timer.sv | 31 +++
 rtl/tempsens_meas_seq.sv | 180 ++++++++++++++++++
 tb/tb_tempsens_meas_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tempsens_pkg.sv
// Shared types and constants for the ring-oscillator temperature sensor sequencer.
package tempsens_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        GATE   = 3'd2,
        LATCH  = 3'd3,
        TX_HI  = 3'd4,
        TX_LO  = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_SINGLE = 8'h00;
    localparam logic [7:0]  CMD_CONT   = 8'h01;
    localparam logic [7:0]  CMD_STOP   = 8'h02;

    localparam logic [15:0] SAT_VALUE  = 16'hFFFF;

endpackage

// File: rtl/tempsens_window_timer.sv
// Loadable down-counter shared by the settle and gate phases; done while the count sits at zero.
module tempsens_window_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);
    import tempsens_pkg::*;

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    // Reload on phase entry, otherwise count down and park at zero so it never wraps.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tempsens_meas_seq.sv
// Measurement sequencer: command decode, RO settle/gate timing, result latch and 2-byte UART return.
module tempsens_meas_seq #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    output logic             ro_en,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_value,
    input  logic             cnt_ovf,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             busy,
    output logic             cont_mode,
    output logic             cmd_drop
);
    import tempsens_pkg::*;

    // Timer is loaded with N-1 so that a phase lasts exactly N cycles ending on count zero.
    localparam int unsigned MAX_CYC     = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int unsigned TMR_W       = $clog2(MAX_CYC) + 1;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic               stop_flag;
    logic               tx_gap;
    logic [CNT_W-1:0]   result;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_value;
    logic               tmr_done;
    logic               tx_hs;
    logic               is_start_cmd;
    logic               cmd_accept;
    logic               cmd_stop_busy;
    logic               cmd_reject;
    logic               frame_end_idle;

    tempsens_window_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clr        (!en),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    assign tx_hs          = tx_valid && tx_ready;
    assign is_start_cmd   = (cmd_data == CMD_SINGLE) || (cmd_data == CMD_CONT);
    assign cmd_accept     = cmd_valid && (state == IDLE) && is_start_cmd;
    assign cmd_stop_busy  = cmd_valid && (state != IDLE) && (cmd_data == CMD_STOP);
    assign cmd_reject     = cmd_valid && !cmd_accept && (cmd_data != CMD_STOP);
    assign frame_end_idle = (state == TX_LO) && tx_hs && !(cont_mode && !stop_flag);

    // State register; reset and en-low both force IDLE.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and timer reload on entry to SETTLE and GATE.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_value  = SETTLE_LOAD;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    next_state = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_value  = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (tmr_done) begin
                    next_state = GATE;
                    tmr_load   = 1'b1;
                    tmr_value  = WINDOW_LOAD;
                end
            end
            GATE: begin
                if (tmr_done) begin
                    next_state = LATCH;
                end
            end
            LATCH: begin
                next_state = TX_HI;
            end
            TX_HI: begin
                if (tx_hs) begin
                    next_state = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_hs) begin
                    if (cont_mode && !stop_flag) begin
                        next_state = SETTLE;
                        tmr_load   = 1'b1;
                        tmr_value  = SETTLE_LOAD;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode; tx_gap holds tx_valid low for one cycle between the two bytes.
    always_comb begin
        ro_en    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = (state != IDLE);
        case (state)
            SETTLE: begin
                ro_en   = 1'b1;
                cnt_clr = 1'b1;
            end
            GATE: begin
                ro_en  = 1'b1;
                cnt_en = 1'b1;
            end
            TX_HI: begin
                tx_valid = 1'b1;
                tx_data  = result[15:8];
            end
            TX_LO: begin
                tx_valid = !tx_gap;
                tx_data  = result[7:0];
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    // Result latch, mode/stop flags and the registered drop pulse.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            result    <= '0;
            cont_mode <= 1'b0;
            stop_flag <= 1'b0;
            tx_gap    <= 1'b0;
            cmd_drop  <= 1'b0;
        end else begin
            cmd_drop <= cmd_reject;
            tx_gap   <= (state == TX_HI) && tx_hs;
            if (state == LATCH) begin
                result <= cnt_ovf ? SAT_VALUE : cnt_value;
            end
            if (cmd_accept) begin
                cont_mode <= (cmd_data == CMD_CONT);
            end else if (frame_end_idle) begin
                cont_mode <= 1'b0;
                stop_flag <= 1'b0;
            end else if (cmd_stop_busy) begin
                stop_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tempsens_meas_seq.sv
// Directed bench for the measurement sequencer with small settle/window values.
module tb_tempsens_meas_seq;

    localparam int unsigned S = 4;
    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        ro_en;
    logic        cnt_clr;
    logic        cnt_en;
    logic [15:0] cnt_value;
    logic        cnt_ovf;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        cont_mode;
    logic        cmd_drop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Monitor state, cleared by the stimulus between steps.
    int        ro_cnt, clr_cnt, en_cnt, drop_cnt;
    int        stab_viol, gap_viol;
    int        first_valid_cyc;
    bit        valid_seen;
    int        acc_cyc, lat_base;
    logic [7:0] rx_q[$];
    logic      prev_valid, prev_ready;
    logic [7:0] prev_data;

    wire [14:0] out_vec = {ro_en, cnt_clr, cnt_en, tx_valid, busy, cont_mode, cmd_drop, tx_data};

    tempsens_meas_seq #(
        .SETTLE_CYCLES (S),
        .WINDOW_CYCLES (W),
        .CNT_W         (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .ro_en     (ro_en),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .cnt_value (cnt_value),
        .cnt_ovf   (cnt_ovf),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .cont_mode (cont_mode),
        .cmd_drop  (cmd_drop)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Negedge monitor: phase lengths, captured bytes, hold stability and inter-byte gap.
    always @(negedge clk) begin
        if (ro_en)    ro_cnt++;
        if (cnt_clr)  clr_cnt++;
        if (cnt_en)   en_cnt++;
        if (cmd_drop) drop_cnt++;
        if (tx_valid && !valid_seen) begin
            valid_seen      = 1'b1;
            first_valid_cyc = cyc;
        end
        if (prev_valid && !prev_ready && !(tx_valid && tx_data == prev_data)) stab_viol++;
        if (prev_valid && prev_ready && tx_valid) gap_viol++;
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMon();
        ro_cnt = 0; clr_cnt = 0; en_cnt = 0; drop_cnt = 0;
        stab_viol = 0; gap_viol = 0;
        valid_seen = 1'b0; first_valid_cyc = 0;
        rx_q.delete();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle command pulse; acc_cyc records the edge that samples it.
    task automatic applyStimulus(input logic [7:0] cmd);
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    // Bounded wait: 0 = busy low, 1 = tx_valid high, 2 = cnt_en high.
    task automatic waitFor(input int what, input int limit, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((what == 0 && !busy) || (what == 1 && tx_valid) || (what == 2 && cnt_en)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("[TB] FAIL %s timeout observed=0 expected=1", tag);
        end
    endtask

    task automatic waitBytes(input int n, input int limit, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rx_q.size() >= n) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("[TB] FAIL %s timeout observed=%0d expected=%0d", tag, rx_q.size(), n);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
        cnt_value = 16'h1234; cnt_ovf = 1'b0; tx_ready = 1'b1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00;
        clearMon();

        // Reset state.
        repeat (3) tick();
        checkOutput("reset_outs", 32'(out_vec), 32'h0);
        reset = 1'b1;
        tick();
        checkOutput("idle_outs", 32'(out_vec), 32'h0);

        // Single measurement, tx_ready always high.
        clearMon();
        applyStimulus(8'h00);
        checkOutput("t1_settle_outs", {29'd0, busy, cnt_clr, ro_en}, 32'h7);
        checkOutput("t1_cont_mode", 32'(cont_mode), 32'h0);
        waitFor(0, 100, "t1_idle");
        checkOutput("t1_ro_cycles", ro_cnt, 12);
        checkOutput("t1_clr_cycles", clr_cnt, 4);
        checkOutput("t1_gate_cycles", en_cnt, 8);
        checkOutput("t1_latency", first_valid_cyc - acc_cyc, S + W + 1);
        checkOutput("t1_nbytes", rx_q.size(), 2);
        checkOutput("t1_bytes", {rx_q[0], rx_q[1]}, 16'h1234);
        checkOutput("t1_gap", gap_viol, 0);

        // Back-pressure: each byte held 5 cycles before acceptance.
        clearMon();
        tx_ready = 1'b0;
        applyStimulus(8'h00);
        waitFor(1, 50, "t2_hi_valid");
        checkOutput("t2_hi_data", 32'(tx_data), 32'h12);
        repeat (5) tick();
        checkOutput("t2_hi_held", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h12});
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checkOutput("t2_gap_low", 32'(tx_valid), 32'h0);
        waitFor(1, 10, "t2_lo_valid");
        checkOutput("t2_lo_data", 32'(tx_data), 32'h34);
        repeat (5) tick();
        checkOutput("t2_lo_held", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h34});
        tx_ready = 1'b1;
        tick();
        waitFor(0, 10, "t2_idle");
        checkOutput("t2_nbytes", rx_q.size(), 2);
        checkOutput("t2_bytes", {rx_q[0], rx_q[1]}, 16'h1234);
        checkOutput("t2_stability", stab_viol, 0);

        // Continuous mode, stop during the second gate window.
        clearMon();
        cnt_value = 16'hA55A;
        applyStimulus(8'h01);
        checkOutput("t3_cont_on", 32'(cont_mode), 32'h1);
        waitBytes(2, 60, "t3_frame1");
        waitFor(2, 60, "t3_gate2");
        repeat (2) tick();
        applyStimulus(8'h02);
        waitFor(0, 300, "t3_idle");
        checkOutput("t3_nbytes", rx_q.size(), 4);
        checkOutput("t3_bytes", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 32'hA55A_A55A);
        checkOutput("t3_cont_off", 32'(cont_mode), 32'h0);
        checkOutput("t3_no_drop", drop_cnt, 0);
        repeat (20) tick();
        checkOutput("t3_stays_idle", {31'd0, busy}, 32'h0);

        // Overflow saturation.
        clearMon();
        cnt_value = 16'h0042;
        cnt_ovf   = 1'b1;
        applyStimulus(8'h00);
        waitFor(0, 100, "t4_idle");
        checkOutput("t4_bytes", {rx_q[0], rx_q[1]}, 16'hFFFF);
        cnt_ovf = 1'b0;

        // Reset in the third gate cycle, then a clean frame.
        clearMon();
        applyStimulus(8'h00);
        waitFor(2, 30, "t5_gate");
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checkOutput("t5_reset_outs", 32'(out_vec), 32'h0);
        reset = 1'b1;
        clearMon();
        cnt_value = 16'hBEEF;
        applyStimulus(8'h00);
        waitFor(0, 100, "t5_idle");
        checkOutput("t5_ro_cycles", ro_cnt, 12);
        checkOutput("t5_bytes", {rx_q[0], rx_q[1]}, 16'hBEEF);

        // Same abort through en low.
        clearMon();
        applyStimulus(8'h00);
        waitFor(2, 30, "t5e_gate");
        repeat (2) tick();
        en = 1'b0;
        tick();
        checkOutput("t5e_abort_outs", 32'(out_vec), 32'h0);
        en = 1'b1;
        clearMon();
        cnt_value = 16'h0F0E;
        applyStimulus(8'h00);
        waitFor(0, 100, "t5e_idle");
        checkOutput("t5e_gate_cycles", en_cnt, 8);
        checkOutput("t5e_bytes", {rx_q[0], rx_q[1]}, 16'h0F0E);

        // Dropped commands: invalid byte in IDLE, start command during SETTLE.
        clearMon();
        cnt_value = 16'h5A5A;
        applyStimulus(8'h7F);
        checkOutput("t6_drop_idle", {30'd0, cmd_drop, busy}, 32'h2);
        tick();
        checkOutput("t6_drop_pulse", 32'(cmd_drop), 32'h0);
        applyStimulus(8'h00);
        lat_base = acc_cyc;
        tick();
        applyStimulus(8'h00);
        checkOutput("t6_drop_busy", 32'(cmd_drop), 32'h1);
        waitFor(0, 100, "t6_idle");
        checkOutput("t6_latency", first_valid_cyc - lat_base, S + W + 1);
        checkOutput("t6_ro_cycles", ro_cnt, 12);
        checkOutput("t6_drop_count", drop_cnt, 2);
        checkOutput("t6_bytes", {rx_q[0], rx_q[1]}, 16'h5A5A);
        checkOutput("t6_nbytes", rx_q.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
